// File: rtl/fighter_sprite_fetch_pkg.sv
`default_nettype none
// ============================================================================
// fighter_pkg - pose / ROM-select enumerations and sprite geometry
// Rev 1.0
// ============================================================================
package fighter_pkg;

    localparam int SPR_W  = 64;
    localparam int SPR_H  = 64;
    localparam int ADDR_W = $clog2(SPR_W * SPR_H);

    typedef enum logic [2:0] {
        STAND       = 3'd0,
        BLOCK       = 3'd1,
        CROUCH      = 3'd2,
        CROUCHPUNCH = 3'd3,
        DEAD        = 3'd4,
        JUMP        = 3'd5,
        KICK        = 3'd6,
        PUNCH       = 3'd7
    } pose_e;

    typedef enum logic [3:0] {
        ROM_STAND       = 4'd0,
        ROM_STAND2      = 4'd1,
        ROM_BLOCK       = 4'd2,
        ROM_CROUCH      = 4'd3,
        ROM_CROUCHPUNCH = 4'd4,
        ROM_DEAD        = 4'd5,
        ROM_JUMP        = 4'd6,
        ROM_KICK        = 4'd7,
        ROM_PUNCH       = 4'd8
    } rom_sel_e;

    function automatic rom_sel_e pose_to_rom(pose_e p);
        case (p)
            BLOCK:       return ROM_BLOCK;
            CROUCH:      return ROM_CROUCH;
            CROUCHPUNCH: return ROM_CROUCHPUNCH;
            DEAD:        return ROM_DEAD;
            JUMP:        return ROM_JUMP;
            KICK:        return ROM_KICK;
            PUNCH:       return ROM_PUNCH;
            default:     return ROM_STAND;
        endcase
    endfunction

    function automatic logic is_attack(pose_e p);
        return (p == PUNCH) || (p == KICK) || (p == CROUCHPUNCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fighter_sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// fighter_sprite_fetch_if - draw/pose inputs, ROM bus and pixel outputs
// Rev 1.0
// ============================================================================
interface fighter_sprite_fetch_if;
    import fighter_pkg::*;

    logic              frame_start;
    logic [9:0]        draw_x;
    logic [9:0]        draw_y;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              facing_left;
    pose_e             pose_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        q_stand;
    logic [3:0]        q_stand2;
    logic [3:0]        q_block;
    logic [3:0]        q_crouch;
    logic [3:0]        q_crouchpunch;
    logic [3:0]        q_dead;
    logic [3:0]        q_jump;
    logic [3:0]        q_kick;
    logic [3:0]        q_punch;
    logic [3:0]        pix_idx;
    logic              pix_on;
    rom_sel_e          cur_rom;

    modport master (
        output frame_start, draw_x, draw_y, pos_x, pos_y, facing_left, pose_req,
        output q_stand, q_stand2, q_block, q_crouch, q_crouchpunch,
        output q_dead, q_jump, q_kick, q_punch,
        input  rom_addr, pix_idx, pix_on, cur_rom
    );

    modport slave (
        input  frame_start, draw_x, draw_y, pos_x, pos_y, facing_left, pose_req,
        input  q_stand, q_stand2, q_block, q_crouch, q_crouchpunch,
        input  q_dead, q_jump, q_kick, q_punch,
        output rom_addr, pix_idx, pix_on, cur_rom
    );
endinterface
`default_nettype wire

// File: rtl/fighter_pose_fsm.sv
`default_nettype none
// ============================================================================
// fighter_pose_fsm - frame-rate pose sequencer (idle alternation, attack hold,
// terminal dead); emits the ROM select, updated only on frame_start
// Rev 1.0
// ============================================================================
module fighter_pose_fsm
    import fighter_pkg::*;
#(
    parameter int STAND_PERIOD  = 16,
    parameter int ATTACK_FRAMES = 12
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     frame_start,
    input  pose_e    pose_req,
    output rom_sel_e rom_sel
);

    localparam int FC_W = (STAND_PERIOD  > 1) ? $clog2(STAND_PERIOD)  : 1;
    localparam int HC_W = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(STAND_PERIOD - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(ATTACK_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_STAND_A = 3'd0,
        ST_STAND_B = 3'd1,
        ST_HOLD    = 3'd2,
        ST_FREE    = 3'd3,
        ST_DEAD    = 3'd4
    } state_e;

    state_e          r_state;
    logic [FC_W-1:0] r_frame_cnt;
    logic [HC_W-1:0] r_hold_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_STAND_A;
            r_frame_cnt <= '0;
            r_hold_cnt  <= '0;
            rom_sel     <= ROM_STAND;
        end else if (frame_start) begin
            if (pose_req == DEAD) begin
                r_state <= ST_DEAD;
                rom_sel <= ROM_DEAD;
            end else if (r_state == ST_DEAD) begin
                r_state <= ST_DEAD;
            end else if ((r_state == ST_HOLD) && (r_hold_cnt != HC_LAST)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else if (pose_req == STAND) begin
                // Staying idle keeps the alternation phase; arriving idle restarts it
                if ((r_state == ST_STAND_A) || (r_state == ST_STAND_B)) begin
                    if (r_frame_cnt == FC_LAST) begin
                        r_frame_cnt <= '0;
                        r_state     <= (r_state == ST_STAND_A) ? ST_STAND_B : ST_STAND_A;
                        rom_sel     <= (r_state == ST_STAND_A) ? ROM_STAND2 : ROM_STAND;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end else begin
                    r_state     <= ST_STAND_A;
                    r_frame_cnt <= '0;
                    rom_sel     <= ROM_STAND;
                end
            end else if (is_attack(pose_req)) begin
                r_state    <= ST_HOLD;
                r_hold_cnt <= '0;
                rom_sel    <= pose_to_rom(pose_req);
            end else begin
                r_state <= ST_FREE;
                rom_sel <= pose_to_rom(pose_req);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fighter_sprite_fetch.sv
`default_nettype none
// ============================================================================
// fighter_sprite_fetch - draw coordinate to mirrored ROM address, pose select,
// and 3-cycle aligned palette index / opaque flag
// Rev 1.0
// ============================================================================
module fighter_sprite_fetch
    import fighter_pkg::*;
#(
    parameter int         STAND_PERIOD    = 16,
    parameter int         ATTACK_FRAMES   = 12,
    parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
    input  logic                   clock,
    input  logic                   reset,
    fighter_sprite_fetch_if.slave  bus
);

    localparam int              XB      = $clog2(SPR_W);
    localparam int              YB      = $clog2(SPR_H);
    localparam logic [9:0]      BOX_W   = 10'(SPR_W);
    localparam logic [9:0]      BOX_H   = 10'(SPR_H);
    localparam logic [XB-1:0]   COL_MAX = '1;

    logic [9:0]        w_rx;
    logic [9:0]        w_ry;
    logic              w_in_box;
    logic [XB-1:0]     w_col;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_q;
    rom_sel_e          w_sel;

    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_in_box1;
    logic              r_in_box2;
    rom_sel_e          r_sel1;
    rom_sel_e          r_sel2;
    logic [3:0]        r_pix_idx;
    logic              r_pix_on;

    fighter_pose_fsm #(
        .STAND_PERIOD  (STAND_PERIOD),
        .ATTACK_FRAMES (ATTACK_FRAMES)
    ) u_pose_fsm (
        .clock       (clock),
        .reset       (reset),
        .frame_start (bus.frame_start),
        .pose_req    (bus.pose_req),
        .rom_sel     (w_sel)
    );

    // The >= terms reject coordinates that only land in the box through wrap-around
    always_comb begin
        w_rx     = bus.draw_x - bus.pos_x;
        w_ry     = bus.draw_y - bus.pos_y;
        w_in_box = (bus.draw_x >= bus.pos_x) && (w_rx < BOX_W) &&
                   (bus.draw_y >= bus.pos_y) && (w_ry < BOX_H);
        w_col    = bus.facing_left ? (COL_MAX - w_rx[XB-1:0]) : w_rx[XB-1:0];
        w_addr   = w_in_box ? {w_ry[YB-1:0], w_col} : '0;
    end

    always_comb begin
        w_q = '0;
        case (r_sel2)
            ROM_STAND:       w_q = bus.q_stand;
            ROM_STAND2:      w_q = bus.q_stand2;
            ROM_BLOCK:       w_q = bus.q_block;
            ROM_CROUCH:      w_q = bus.q_crouch;
            ROM_CROUCHPUNCH: w_q = bus.q_crouchpunch;
            ROM_DEAD:        w_q = bus.q_dead;
            ROM_JUMP:        w_q = bus.q_jump;
            ROM_KICK:        w_q = bus.q_kick;
            ROM_PUNCH:       w_q = bus.q_punch;
            default:         w_q = '0;
        endcase
    end

    // Select travels alongside the address so it lines up with the ROM's registered q
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_in_box1  <= 1'b0;
            r_in_box2  <= 1'b0;
            r_sel1     <= ROM_STAND;
            r_sel2     <= ROM_STAND;
            r_pix_idx  <= '0;
            r_pix_on   <= 1'b0;
        end else begin
            r_rom_addr <= w_addr;
            r_in_box1  <= w_in_box;
            r_sel1     <= w_sel;
            r_in_box2  <= r_in_box1;
            r_sel2     <= r_sel1;
            r_pix_idx  <= w_q;
            r_pix_on   <= r_in_box2 && (w_q != TRANSPARENT_IDX);
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.pix_idx  = r_pix_idx;
    assign bus.pix_on   = r_pix_on;
    assign bus.cur_rom  = w_sel;

endmodule
`default_nettype wire
